// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared widths, FSM states and address-field helpers for ram_bank_arbiter
package ram_arb_pkg;
    localparam int DATA_W = 4;
    localparam int ROW_W  = 2;
    localparam int COL_W  = 2;
    localparam int ADDR_W = 1 + ROW_W + COL_W;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    typedef logic [0:0] req_idx_t;

    function automatic logic bank_of(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1];
    endfunction

    function automatic logic [ROW_W-1:0] row_of(input logic [ADDR_W-1:0] a);
        return a[COL_W+:ROW_W];
    endfunction

    function automatic logic [COL_W-1:0] col_of(input logic [ADDR_W-1:0] a);
        return a[COL_W-1:0];
    endfunction
endpackage

// File: rtl/ram_bank_arbiter_if.sv
// ram_bank_arbiter_if: requester and RAM-side signals of the arbiter; slave is the arbiter
interface ram_bank_arbiter_if;
    import ram_arb_pkg::*;
    logic [1:0]          req;
    logic [1:0]          req_we;
    logic [2*ADDR_W-1:0] req_addr;
    logic [2*DATA_W-1:0] req_wdata;
    logic [1:0]          gnt;
    logic [1:0]          rvalid;
    logic [DATA_W-1:0]   rdata;
    logic                cs;
    logic                we;
    logic                oe;
    logic                bank_selector;
    logic [ROW_W-1:0]    addr_row;
    logic [COL_W-1:0]    addr_col;
    logic [DATA_W-1:0]   datain;
    logic [DATA_W-1:0]   dataout;

    modport master (
        output req, req_we, req_addr, req_wdata, dataout,
        input  gnt, rvalid, rdata, cs, we, oe, bank_selector, addr_row, addr_col, datain
    );
    modport slave (
        input  req, req_we, req_addr, req_wdata, dataout,
        output gnt, rvalid, rdata, cs, we, oe, bank_selector, addr_row, addr_col, datain
    );
endinterface

// File: rtl/ram_bank_arbiter_rr_arb2.sv
// rr_arb2: two-way arbiter; ties go to the requester not granted last, or always
// to req0 when RAM_ARB_FIXED_PRIO_EN is defined
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       adv_i,
    output logic [1:0] gnt_o
);
    logic last_q;
    logic last_d;
    logic tie_to_0;

`ifdef RAM_ARB_FIXED_PRIO_EN
    assign tie_to_0 = 1'b1;
`else
    assign tie_to_0 = last_q;
`endif

    assign gnt_o  = &req_i ? (tie_to_0 ? 2'b01 : 2'b10) : req_i;
    assign last_d = (adv_i && |req_i) ? gnt_o[1] : last_q;

    // last granted starts as req1 so req0 wins the first tie
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) last_q <= 1'b1;
        else last_q <= last_d;
endmodule

// File: rtl/ram_bank_arbiter.sv
// ram_bank_arbiter: two-requester sequencer for the 2-bank basic RAM, one access at a time.
// Tie-break policy selectable with RAM_ARB_FIXED_PRIO_EN (handled in rr_arb2).
module ram_bank_arbiter
    import ram_arb_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input logic               clk,
    input logic               rst_n,
    ram_bank_arbiter_if.slave bus
);
    state_t            state_q;
    req_idx_t          win_q;
    req_idx_t          win_d;
    logic [1:0]        cnt_q;
    logic [1:0]        pick;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    rr_arb2 u_arb (
        .clk  (clk),
        .rst_n(rst_n),
        .req_i(bus.req),
        .adv_i(state_q == IDLE),
        .gnt_o(pick)
    );

    assign win_d     = pick[1];
    assign sel_we    = bus.req_we[win_d];
    assign sel_addr  = win_d ? bus.req_addr[2*ADDR_W-1:ADDR_W] : bus.req_addr[ADDR_W-1:0];
    assign sel_wdata = win_d ? bus.req_wdata[2*DATA_W-1:DATA_W] : bus.req_wdata[DATA_W-1:0];

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q           <= IDLE;
            win_q             <= '0;
            cnt_q             <= '0;
            bus.gnt           <= '0;
            bus.rvalid        <= '0;
            bus.rdata         <= '0;
            bus.cs            <= 1'b0;
            bus.we            <= 1'b0;
            bus.oe            <= 1'b0;
            bus.bank_selector <= 1'b0;
            bus.addr_row      <= '0;
            bus.addr_col      <= '0;
            bus.datain        <= '0;
        end else begin
            bus.gnt    <= '0;
            bus.rvalid <= '0;
            case (state_q)
                IDLE: if (|bus.req) begin
                    state_q           <= ISSUE;
                    win_q             <= win_d;
                    bus.gnt           <= pick;
                    bus.cs            <= 1'b1;
                    bus.we            <= sel_we;
                    bus.oe            <= !sel_we;
                    bus.bank_selector <= bank_of(sel_addr);
                    bus.addr_row      <= row_of(sel_addr);
                    bus.addr_col      <= col_of(sel_addr);
                    if (sel_we) bus.datain <= sel_wdata;
                end
                ISSUE: begin
                    state_q <= bus.we ? IDLE : WAIT;
                    cnt_q   <= 2'(RD_LAT - 1);
                    bus.cs  <= !bus.we;
                    bus.we  <= 1'b0;
                end
                WAIT: if (cnt_q == '0) begin
                    state_q    <= RESP;
                    bus.rdata  <= bus.dataout;
                    bus.rvalid <= win_q[0] ? 2'b10 : 2'b01;
                    bus.cs     <= 1'b0;
                    bus.oe     <= 1'b0;
                end else begin
                    cnt_q <= cnt_q - 2'd1;
                end
                default: state_q <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_ram_bank_arbiter.sv
// tb_ram_bank_arbiter: directed checks of arbitration, RAM strobes and read latency
// on three arbiters with RD_LAT = 1, 2, 3, each driving its own RAM model
module tb_ram_bank_arbiter;
    import ram_arb_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int total = 0;
    int bad = 0;

    logic [1:0]          req_v [3];
    logic [1:0]          we_v  [3];
    logic [2*ADDR_W-1:0] addr_v[3];
    logic [2*DATA_W-1:0] wd_v  [3];
    logic [1:0]          gnt_v [3];
    logic [1:0]          rv_v  [3];
    logic [DATA_W-1:0]   rd_v  [3];
    logic [11:0]         strb_v[3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gi
        ram_bank_arbiter_if bus ();
        logic [DATA_W-1:0] mem [32];
        logic [DATA_W-1:0] pipe[3];
        always @(posedge clk) begin
            if (bus.cs && bus.we) mem[{bus.bank_selector, bus.addr_row, bus.addr_col}] <= bus.datain;
            pipe[0] <= (bus.cs && bus.oe) ? mem[{bus.bank_selector, bus.addr_row, bus.addr_col}] : '0;
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
        end
        assign bus.dataout   = pipe[g];
        assign bus.req       = req_v[g];
        assign bus.req_we    = we_v[g];
        assign bus.req_addr  = addr_v[g];
        assign bus.req_wdata = wd_v[g];
        assign gnt_v[g]      = bus.gnt;
        assign rv_v[g]       = bus.rvalid;
        assign rd_v[g]       = bus.rdata;
        assign strb_v[g]     = {bus.cs, bus.we, bus.oe, bus.bank_selector, bus.addr_row, bus.addr_col, bus.datain};
        ram_bank_arbiter #(.RD_LAT(g + 1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    end

    // the idle requester's half carries inverted values so a wrong select shows up
    task automatic drive(input int k, input logic [1:0] r, input logic w, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
        req_v[k]  = r;
        we_v[k]   = r[1] ? {w, ~w} : {~w, w};
        addr_v[k] = r[1] ? {a, ~a} : {~a, a};
        wd_v[k]   = r[1] ? {d, ~d} : {~d, d};
    endtask

    task automatic wr_txn(input int k, input logic [1:0] r, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        drive(k, r, 1'b1, a, d);
        @(negedge clk);
        req_v[k] = '0;
        total++;
        if ({gnt_v[k], strb_v[k]} !== {r, 3'b110, a, d}) begin
            bad++;
            $display("FAIL wr_issue k=%0d: got gnt/strobes %h want %h", k, {gnt_v[k], strb_v[k]}, {r, 3'b110, a, d});
        end
        @(negedge clk);
        total++;
        if ({gnt_v[k], strb_v[k][11:9]} !== 5'b00000) begin
            bad++;
            $display("FAIL wr_idle k=%0d: got gnt/cs/we/oe %b want 00000", k, {gnt_v[k], strb_v[k][11:9]});
        end
    endtask

    task automatic rd_txn(input int k, input logic [1:0] r, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] expd);
        int first = 0;
        int n = 0;
        logic [1:0] val = '0;
        logic [DATA_W-1:0] dat = '0;
        drive(k, r, 1'b0, a, '0);
        @(negedge clk);
        req_v[k] = '0;
        total++;
        if ({gnt_v[k], strb_v[k][11:4]} !== {r, 3'b101, a}) begin
            bad++;
            $display("FAIL rd_issue k=%0d: got %h want %h", k, {gnt_v[k], strb_v[k][11:4]}, {r, 3'b101, a});
        end
        for (int j = 1; j <= k + 4; j++) begin
            @(negedge clk);
            if (rv_v[k] != 2'b00) begin
                n++;
                if (first == 0) begin
                    first = j;
                    val = rv_v[k];
                    dat = rd_v[k];
                end
            end
        end
        total++;
        if (first != k + 2) begin
            bad++;
            $display("FAIL rd_latency k=%0d: got rvalid at %0d want %0d", k, first, k + 2);
        end
        total++;
        if (n != 1) begin
            bad++;
            $display("FAIL rd_pulse k=%0d: got %0d rvalid cycles want 1", k, n);
        end
        total++;
        if ({val, dat} !== {r, expd}) begin
            bad++;
            $display("FAIL rd_data k=%0d: got rvalid/rdata %h want %h", k, {val, dat}, {r, expd});
        end
    endtask

    task automatic test_reset();
        int n = 0;
        #3 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            total++;
            if ({gnt_v[k], rv_v[k], rd_v[k], strb_v[k]} !== '0) begin
                bad++;
                $display("FAIL reset_vals k=%0d: got %h want 0", k, {gnt_v[k], rv_v[k], rd_v[k], strb_v[k]});
            end
        end
        @(negedge clk) rst_n = 1'b1;
        drive(0, 2'b01, 1'b0, 5'b1_11_01, '0);
        @(negedge clk) req_v[0] = '0;
        @(negedge clk);
        total++;
        if (strb_v[0][11:9] !== 3'b101) begin
            bad++;
            $display("FAIL reset_wait: got cs/we/oe %b want 101", strb_v[0][11:9]);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({gnt_v[0], rv_v[0], rd_v[0], strb_v[0]} !== '0) begin
            bad++;
            $display("FAIL reset_mid: got %h want 0", {gnt_v[0], rv_v[0], rd_v[0], strb_v[0]});
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (rv_v[0] != 2'b00 || gnt_v[0] != 2'b00) n++;
        end
        total++;
        if (n != 0) begin
            bad++;
            $display("FAIL reset_discard: got %0d cycles of rvalid/gnt want 0", n);
        end
    endtask

    task automatic test_write_read();
        wr_txn(0, 2'b01, 5'b1_11_01, 4'b1000);
        rd_txn(0, 2'b01, 5'b1_11_01, 4'b1000);
    endtask

    task automatic test_bank_isolation();
        wr_txn(0, 2'b10, 5'b0_11_11, 4'b1011);
        rd_txn(0, 2'b01, 5'b1_11_01, 4'b1000);
        rd_txn(0, 2'b10, 5'b0_11_11, 4'b1011);
        rd_txn(0, 2'b01, 5'b0_11_11, 4'b1011);
    endtask

    task automatic test_round_robin();
        logic [1:0] seen;
        logic [1:0] expg;
        @(negedge clk) rst_n = 1'b0;
        #2 rst_n = 1'b1;
        req_v[0]  = 2'b11;
        we_v[0]   = 2'b11;
        addr_v[0] = {5'b0_00_01, 5'b0_00_00};
        wd_v[0]   = 8'h21;
        for (int i = 0; i < 4; i++) begin
            seen = '0;
            for (int j = 0; j < 4 && seen == 2'b00; j++) begin
                @(negedge clk);
                seen = gnt_v[0];
            end
`ifdef RAM_ARB_FIXED_PRIO_EN
            expg = 2'b01;
`else
            expg = (i % 2 == 1) ? 2'b10 : 2'b01;
`endif
            total++;
            if (seen !== expg) begin
                bad++;
                $display("FAIL rr_grant%0d: got gnt %b want %b", i, seen, expg);
            end
        end
        req_v[0] = '0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_no_queueing();
        int fg = 0;
        int f1 = 0;
        int f2 = 0;
        logic [1:0] gv = '0;
        logic [1:0] v1 = '0;
        logic [1:0] v2 = '0;
        logic [DATA_W-1:0] d1 = '0;
        logic [DATA_W-1:0] d2 = '0;
        drive(0, 2'b01, 1'b0, 5'b1_11_01, '0);
        @(negedge clk) req_v[0] = '0;
        for (int j = 1; j <= 9; j++) begin
            @(negedge clk);
            if (gnt_v[0] != 2'b00 && fg == 0) begin
                fg = j;
                gv = gnt_v[0];
                req_v[0] = '0;
            end
            if (rv_v[0] != 2'b00) begin
                if (f1 == 0) begin
                    f1 = j;
                    v1 = rv_v[0];
                    d1 = rd_v[0];
                end else if (f2 == 0) begin
                    f2 = j;
                    v2 = rv_v[0];
                    d2 = rd_v[0];
                end
            end
            if (j == 1) drive(0, 2'b10, 1'b0, 5'b0_11_11, '0);
        end
        total++;
        if (f1 != 2 || {v1, d1} !== {2'b01, 4'b1000}) begin
            bad++;
            $display("FAIL nq_first_read: got cycle %0d rvalid/rdata %h want cycle 2 %h", f1, {v1, d1}, {2'b01, 4'b1000});
        end
        total++;
        if (fg != 4 || gv !== 2'b10) begin
            bad++;
            $display("FAIL nq_late_gnt: got cycle %0d gnt %b want cycle 4 gnt 10", fg, gv);
        end
        total++;
        if (f2 != 6 || {v2, d2} !== {2'b10, 4'b1011}) begin
            bad++;
            $display("FAIL nq_second_read: got cycle %0d rvalid/rdata %h want cycle 6 %h", f2, {v2, d2}, {2'b10, 4'b1011});
        end
    endtask

    task automatic test_rd_lat_sweep();
        for (int k = 0; k < 3; k++) begin
            wr_txn(k, 2'b01, 5'b1_10_00, 4'(k + 5));
            rd_txn(k, 2'b01, 5'b1_10_00, 4'(k + 5));
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            req_v[k]  = '0;
            we_v[k]   = '0;
            addr_v[k] = '0;
            wd_v[k]   = '0;
        end
        test_reset();
        test_write_read();
        test_bank_isolation();
        test_round_robin();
        test_no_queueing();
        test_rd_lat_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
